// File: rtl/hilo_seq_divider.sv
// hilo_seq_divider: WIDTH-step restoring divider that owns the MIPS HI/LO register pair
// Ports: clk, reset (sync, active-high); SrcAE dividend and mthi/mtlo data; SrcBE divisor;
// divE/signedE divide request and mode; mtHiE/mtLoE move-to writes; Hi remainder, Lo quotient;
// Busy/StallDivE hazard stall; Done one-cycle completion pulse; DivZero divisor-was-zero flag.
module hilo_seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             divE,
    input  logic             signedE,
    input  logic             mtHiE,
    input  logic             mtLoE,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             StallDivE,
    output logic             Done,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;
    stateT state;
    logic [WIDTH-1:0] divisor, quot, rem, magA, magB;
    logic [CW-1:0] count;
    logic qNeg, rNeg, zero;
    logic [WIDTH:0] shifted, trial;
    assign magA = (signedE & SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign magB = (signedE & SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    // one extra bit keeps the trial subtraction exact when the divisor is 2^(WIDTH-1) or above
    assign shifted = {rem, quot[WIDTH-1]};
    assign trial = shifted - {1'b0, divisor};
    assign StallDivE = Busy | (divE & (state == IDLE));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            Hi <= '0;
            Lo <= '0;
            Busy <= 1'b0;
            Done <= 1'b0;
            DivZero <= 1'b0;
            count <= '0;
            divisor <= '0;
            quot <= '0;
            rem <= '0;
            qNeg <= 1'b0;
            rNeg <= 1'b0;
            zero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (divE) begin
                        divisor <= magB;
                        quot <= magA;
                        rem <= '0;
                        count <= '0;
                        qNeg <= (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]) & signedE;
                        rNeg <= SrcAE[WIDTH-1] & signedE;
                        zero <= (SrcBE == '0);
                        DivZero <= 1'b0;
                        Busy <= 1'b1;
                        state <= RUN;
                    end else begin
                        if (mtHiE) Hi <= SrcAE;
                        if (mtLoE) Lo <= SrcAE;
                    end
                end
                RUN: begin
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                default: begin
                    // divide by zero leaves quot all ones and rem=|A|; restoring the dividend
                    // sign on rem yields the original SrcAE, while the quotient is left unsigned
                    Lo <= (qNeg & ~zero) ? -quot : quot;
                    Hi <= rNeg ? -rem : rem;
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    DivZero <= zero;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_seq_divider.sv
// tb_hilo_seq_divider: directed self-checking bench for hilo_seq_divider
module tb_hilo_seq_divider;
    logic clk = 1'b0;
    logic reset;
    logic [31:0] SrcAE, SrcBE;
    logic divE, signedE, mtHiE, mtLoE;
    logic [31:0] Hi, Lo;
    logic Busy, StallDivE, Done, DivZero;
    int checks = 0;
    int errors = 0;
    int doneCnt = 0;

    hilo_seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .SrcAE(SrcAE), .SrcBE(SrcBE), .divE(divE),
        .signedE(signedE), .mtHiE(mtHiE), .mtLoE(mtLoE), .Hi(Hi), .Lo(Lo),
        .Busy(Busy), .StallDivE(StallDivE), .Done(Done), .DivZero(DivZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (Done) doneCnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startDiv(input logic [31:0] a, input logic [31:0] b, input logic s);
        SrcAE = a;
        SrcBE = b;
        signedE = s;
        divE = 1'b1;
        #1;
        check("stall at start", {31'b0, StallDivE}, 32'd1);
        tick();
        divE = 1'b0;
    endtask

    // n is the number of edges already taken since the start edge (start edge counts as 1)
    task automatic waitDone(input string tag, input int n0, input logic [31:0] expLo,
                            input logic [31:0] expHi, input logic expZ);
        int n = n0;
        int busyCnt = 0;
        while (!Done && n < 60) begin
            busyCnt += int'(Busy);
            tick();
            n++;
        end
        check({tag, " done edge"}, n, 34);
        if (n0 == 1) check({tag, " busy cycles"}, busyCnt, 33);
        check({tag, " lo"}, Lo, expLo);
        check({tag, " hi"}, Hi, expHi);
        check({tag, " divzero"}, {31'b0, DivZero}, {31'b0, expZ});
        check({tag, " busy after"}, {31'b0, Busy}, 32'd0);
        tick();
        check({tag, " done one cycle"}, {31'b0, Done}, 32'd0);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        SrcAE = '0; SrcBE = '0; divE = 1'b0; signedE = 1'b0; mtHiE = 1'b0; mtLoE = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("reset hi", Hi, 32'd0);
        check("reset lo", Lo, 32'd0);
        check("reset busy", {31'b0, Busy}, 32'd0);
        check("reset done", {31'b0, Done}, 32'd0);
        check("reset stall", {31'b0, StallDivE}, 32'd0);

        d0 = doneCnt;
        startDiv(32'd100, 32'd7, 1'b0);
        waitDone("divu 100/7", 1, 32'd14, 32'd2, 1'b0);
        check("single done pulse", doneCnt - d0, 32'd1);

        startDiv(32'hFFFFFFF9, 32'd2, 1'b1);
        waitDone("div -7/2", 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        startDiv(32'd7, 32'hFFFFFFFE, 1'b1);
        waitDone("div 7/-2", 1, 32'hFFFFFFFD, 32'd1, 1'b0);

        startDiv(32'h12345678, 32'd0, 1'b1);
        waitDone("div by zero s", 1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        startDiv(32'h12345678, 32'd0, 1'b0);
        waitDone("div by zero u", 1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        startDiv(32'h80000000, 32'hFFFFFFFF, 1'b1);
        waitDone("overflow", 1, 32'h80000000, 32'd0, 1'b0);
        check("divzero cleared", {31'b0, DivZero}, 32'd0);

        startDiv(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        SrcAE = 32'd9; SrcBE = 32'd3; divE = 1'b1;
        tick();
        divE = 1'b0; SrcAE = 32'h0000AAAA; mtHiE = 1'b1;
        tick();
        mtHiE = 1'b0;
        check("hi held during run", Hi, 32'd0);
        check("lo held during run", Lo, 32'h80000000);
        waitDone("ignored reqs", 12, 32'd14, 32'd2, 1'b0);

        SrcAE = 32'hDEADBEEF; mtHiE = 1'b1; mtLoE = 1'b1;
        tick();
        mtHiE = 1'b0; mtLoE = 1'b0;
        check("mthi", Hi, 32'hDEADBEEF);
        check("mtlo", Lo, 32'hDEADBEEF);

        SrcAE = 32'd20; SrcBE = 32'd4; signedE = 1'b0; divE = 1'b1; mtLoE = 1'b1;
        tick();
        divE = 1'b0; mtLoE = 1'b0;
        check("mtlo blocked by div", Lo, 32'hDEADBEEF);
        check("busy after start", {31'b0, Busy}, 32'd1);
        waitDone("div 20/4", 1, 32'd5, 32'd0, 1'b0);

        d0 = doneCnt;
        startDiv(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset mid busy", {31'b0, Busy}, 32'd0);
        check("reset mid hi", Hi, 32'd0);
        check("reset mid lo", Lo, 32'd0);
        for (int i = 0; i < 40; i++) tick();
        check("no done after reset", doneCnt - d0, 32'd0);

        d0 = doneCnt;
        SrcAE = 32'd100; SrcBE = 32'd7; signedE = 1'b0; divE = 1'b1;
        tick();
        SrcAE = 32'd50; SrcBE = 32'd6;
        begin
            int n = 1;
            while (!Done && n < 60) begin
                tick();
                n++;
            end
            check("b2b first edge", n, 34);
            check("b2b first lo", Lo, 32'd14);
            check("b2b first hi", Hi, 32'd2);
            check("b2b stall in done cycle", {31'b0, StallDivE}, 32'd1);
        end
        tick();
        divE = 1'b0;
        check("b2b second busy", {31'b0, Busy}, 32'd1);
        waitDone("b2b second", 1, 32'd8, 32'd2, 1'b0);
        check("b2b done pulses", doneCnt - d0, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
